// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 front-end packer: FSM states and message geometry.
package sha256_pkg;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      ISSUE   = 2'd1,
      WAIT    = 2'd2
   } state_t;

   localparam int MSG_BYTES = 32;
   localparam int IDX_W     = $clog2(MSG_BYTES);

endpackage

// File: rtl/sha256_packer.sv
// Packs a 32-byte framed byte stream into one wide word, starts the hash core with a single
// pulse, and waits (bounded) for its result before accepting the next message.
module sha256_packer
   import sha256_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        s_valid,
   input  logic [7:0]                  s_data,
   input  logic                        s_last,
   output logic                        s_ready,
   output logic                        h_valid,
   output logic [MSG_BYTES-1:0][7:0]   h_data,
   input  logic                        h_done,
   output logic                        err,
   output logic [15:0]                 msg_count
);

   localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_BYTES - 1);

   state_t             state;
   logic [IDX_W-1:0]   idx;
   logic               discard;
   logic [TMO_W-1:0]   tmo;

   // s_ready is registered from the next state so it is low in reset and rises on the first edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= COLLECT;
         idx       <= '0;
         discard   <= 1'b0;
         tmo       <= '0;
         s_ready   <= 1'b0;
         h_valid   <= 1'b0;
         h_data    <= '0;
         err       <= 1'b0;
         msg_count <= '0;
      end else begin
         h_valid <= 1'b0;
         err     <= 1'b0;
         case (state)
            COLLECT: begin
               s_ready <= 1'b1;
               if (s_valid && s_ready) begin
                  if (discard) begin
                     // Dropping the tail of an over-length message until its terminator.
                     if (s_last) discard <= 1'b0;
                  end else begin
                     h_data[idx] <= s_data;
                     if (s_last) begin
                        idx <= '0;
                        if (idx == LAST_IDX) begin
                           state   <= ISSUE;
                           h_valid <= 1'b1;
                           s_ready <= 1'b0;
                        end else begin
                           err <= 1'b1;
                        end
                     end else if (idx == LAST_IDX) begin
                        idx     <= '0;
                        err     <= 1'b1;
                        discard <= 1'b1;
                     end else begin
                        idx <= idx + 1'b1;
                     end
                  end
               end
            end
            ISSUE: begin
               s_ready <= 1'b0;
               tmo     <= '0;
               state   <= WAIT;
            end
            WAIT: begin
               // Completion wins over timeout when both happen in the same cycle.
               if (h_done) begin
                  msg_count <= msg_count + 16'd1;
                  state     <= COLLECT;
                  s_ready   <= 1'b1;
               end else if (tmo == TMO_LAST) begin
                  err     <= 1'b1;
                  state   <= COLLECT;
                  s_ready <= 1'b1;
               end else begin
                  tmo <= tmo + 1'b1;
               end
            end
            default: begin
               state   <= COLLECT;
               s_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_packer.sv
// Scoreboard bench for sha256_packer: a behavioural hash-core responder answers h_valid,
// expected packed words are queued at stimulus time and compared when h_valid fires.
module tb_sha256_packer;

   logic               clk;
   logic               rst_n;
   logic               s_valid;
   logic [7:0]         s_data;
   logic               s_last;
   logic               s_ready;
   logic               h_valid;
   logic [31:0][7:0]   h_data;
   logic               h_done;
   logic               err;
   logic [15:0]        msg_count;

   sha256_packer #(.TIMEOUT_CYCLES(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_valid   (s_valid),
      .s_data    (s_data),
      .s_last    (s_last),
      .s_ready   (s_ready),
      .h_valid   (h_valid),
      .h_data    (h_data),
      .h_done    (h_done),
      .err       (err),
      .msg_count (msg_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int hv_cnt   = 0;
   int err_cnt  = 0;
   int exp_count = 0;
   int auto_done = 1;
   int done_delay = 2;
   int pulse_req = 0;
   logic [255:0] exp_q[$];
   logic [7:0]   msg[64];

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Hash-core stand-in: answers each start pulse after done_delay cycles, or on explicit request.
   initial begin
      int handled = 0;
      h_done = 1'b0;
      forever begin
         @(negedge clk);
         if (pulse_req != handled) begin
            handled = pulse_req;
            h_done = 1'b1;
            @(negedge clk);
            h_done = 1'b0;
         end else if (rst_n && h_valid && auto_done != 0) begin
            repeat (done_delay) @(negedge clk);
            h_done = 1'b1;
            @(negedge clk);
            h_done = 1'b0;
         end
      end
   end

   // Output monitor: pops the scoreboard on every start pulse and counts error pulses.
   initial begin
      forever begin
         @(negedge clk);
         if (h_valid) begin
            hv_cnt++;
            if (exp_q.size() == 0) check("unexpected_h_valid", 256'(h_valid), 256'd0);
            else check("h_data", h_data, exp_q.pop_front());
         end
         if (err) err_cnt++;
      end
   end

   task automatic send_byte(input logic [7:0] d, input logic l);
      int guard = 0;
      @(negedge clk);
      s_valid = 1'b1; s_data = d; s_last = l;
      while (!s_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (!s_ready) check("s_ready_wait", 256'(s_ready), 256'd1);
      @(posedge clk);
      #1 s_valid = 1'b0; s_last = 1'b0;
   endtask

   // Sends msg[0..n-1] with s_last on byte index last_pos; queues the packed word when it must issue.
   task automatic send_msg(input int n, input int last_pos, input bit good);
      logic [255:0] w;
      w = '0;
      for (int i = 0; i < 32; i++) w[i*8 +: 8] = msg[i];
      if (good) exp_q.push_back(w);
      for (int i = 0; i < n; i++) send_byte(msg[i], i == last_pos);
   endtask

   task automatic wait_ready(input string tag);
      int guard = 0;
      @(negedge clk);
      while (!s_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check(tag, 256'(s_ready), 256'd1);
   endtask

   task automatic fill_random();
      for (int i = 0; i < 64; i++) msg[i] = 8'($urandom_range(0, 255));
   endtask

   initial begin
      int e0, h0, cyc;
      rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_s_ready", 256'(s_ready), 256'd0);
      check("rst_h_valid", 256'(h_valid), 256'd0);
      check("rst_err", 256'(err), 256'd0);
      check("rst_msg_count", 256'(msg_count), 256'd0);
      check("rst_h_data", h_data, 256'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("s_ready_after_release", 256'(s_ready), 256'd1);

      // Incrementing message: latency and byte ordering.
      for (int i = 0; i < 64; i++) msg[i] = 8'(i);
      send_msg(32, 31, 1'b1);
      @(negedge clk);
      check("latency_h_valid", 256'(h_valid), 256'd1);
      check("issue_s_ready", 256'(s_ready), 256'd0);
      check("h_data_first", 256'(h_data[0]), 256'h00);
      check("h_data_last", 256'(h_data[31]), 256'h1F);
      exp_count++;
      wait_ready("ready_after_done");
      check("msg_count_1", 256'(msg_count), 256'(exp_count));

      // Several random clean messages.
      for (int k = 0; k < 3; k++) begin
         fill_random();
         send_msg(32, 31, 1'b1);
         exp_count++;
         wait_ready("ready_rand");
         check("msg_count_rand", 256'(msg_count), 256'(exp_count));
      end

      // h_done outside WAIT is ignored.
      pulse_req++;
      repeat (3) @(negedge clk);
      check("stray_h_done", 256'(msg_count), 256'(exp_count));

      // Short message: s_last on 10th byte.
      e0 = err_cnt; h0 = hv_cnt;
      fill_random();
      send_msg(10, 9, 1'b0);
      @(negedge clk);
      check("short_err_pulse", 256'(err), 256'd1);
      repeat (3) @(negedge clk);
      check("short_err_count", 256'(err_cnt - e0), 256'd1);
      check("short_no_h_valid", 256'(hv_cnt - h0), 256'd0);
      fill_random();
      send_msg(32, 31, 1'b1);
      exp_count++;
      wait_ready("ready_after_short");
      check("msg_count_after_short", 256'(msg_count), 256'(exp_count));

      // Long message: 33 bytes, s_last on the 33rd.
      e0 = err_cnt; h0 = hv_cnt;
      fill_random();
      for (int i = 0; i < 32; i++) send_byte(msg[i], 1'b0);
      @(negedge clk);
      check("long_err_at_32", 256'(err), 256'd1);
      check("long_discard_ready", 256'(s_ready), 256'd1);
      send_byte(msg[32], 1'b1);
      repeat (3) @(negedge clk);
      check("long_err_count", 256'(err_cnt - e0), 256'd1);
      check("long_no_h_valid", 256'(hv_cnt - h0), 256'd0);
      fill_random();
      send_msg(32, 31, 1'b1);
      exp_count++;
      wait_ready("ready_after_long");
      check("msg_count_after_long", 256'(msg_count), 256'(exp_count));

      // Timeout: no h_done, err 8 cycles after WAIT entry.
      auto_done = 0;
      fill_random();
      send_msg(32, 31, 1'b1);
      @(negedge clk);
      check("tmo_h_valid", 256'(h_valid), 256'd1);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!err && cyc < 50);
      check("tmo_err_delay", 256'(cyc - 1), 256'd8);
      @(negedge clk);
      check("tmo_s_ready", 256'(s_ready), 256'd1);
      check("tmo_msg_count", 256'(msg_count), 256'(exp_count));

      // h_done on the timeout-limit cycle counts as completion.
      auto_done = 1; done_delay = 8;
      e0 = err_cnt;
      fill_random();
      send_msg(32, 31, 1'b1);
      exp_count++;
      wait_ready("ready_limit_done");
      repeat (2) @(negedge clk);
      check("limit_no_err", 256'(err_cnt - e0), 256'd0);
      check("limit_msg_count", 256'(msg_count), 256'(exp_count));
      done_delay = 2;

      // Reset while in WAIT, then one full message.
      auto_done = 0;
      e0 = err_cnt;
      fill_random();
      send_msg(32, 31, 1'b1);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("midwait_rst_ready", 256'(s_ready), 256'd0);
      rst_n = 1'b1;
      exp_count = 0;
      auto_done = 1;
      h0 = hv_cnt;
      fill_random();
      send_msg(32, 31, 1'b1);
      exp_count++;
      wait_ready("ready_after_rst");
      check("rst_wait_single_h_valid", 256'(hv_cnt - h0), 256'd1);
      check("rst_wait_msg_count", 256'(msg_count), 256'(exp_count));
      check("rst_wait_no_err", 256'(err_cnt - e0), 256'd0);

      repeat (4) @(negedge clk);
      check("scoreboard_empty", 256'(exp_q.size()), 256'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation time limit");
   end

endmodule
